// File: rtl/rv32_icache_if.sv
// Instruction-memory bus between rv32_icache (master) and the memory system (slave).
// One word-sized read beat per mem_ready_in pulse.
interface rv32_icache_if;
    logic        mem_read_out;
    logic [31:0] mem_address_out;
    logic        mem_ready_in;
    logic [31:0] mem_read_value_in;
    logic        mem_fault_in;

    modport master (
        output mem_read_out, mem_address_out,
        input  mem_ready_in, mem_read_value_in, mem_fault_in
    );

    modport slave (
        input  mem_read_out, mem_address_out,
        output mem_ready_in, mem_read_value_in, mem_fault_in
    );
endinterface

// File: rtl/rv32_icache.sv
// Direct-mapped read-only instruction cache with combinational hits and word-beat line refill.
// Optional macro RV32_ICACHE_STATS_EN adds hit_count_out / miss_count_out counters.
module rv32_icache #(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_read_in,
    input  logic [31:0] instr_address_in,
    output logic [31:0] instr_read_value_out,
    output logic        instr_fault_out,
    output logic        instr_stall_out,
    input  logic        flush_in,
    rv32_icache_if.master mem
`ifdef RV32_ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count_out,
    output logic [31:0] miss_count_out
`endif
);
    localparam int INDEX_BITS  = $clog2(LINES);
    localparam int WORD_BITS   = $clog2(LINE_WORDS);
    localparam int OFFSET_BITS = WORD_BITS + 2;
    localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS;
    localparam int CNT_BITS    = (INDEX_BITS > WORD_BITS) ? INDEX_BITS : WORD_BITS;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_INVAL, S_IDLE, S_REFILL, S_FAULT} state_t;

    state_t                r_state;
    logic [CNT_BITS-1:0]   r_cnt;
    logic                  r_flushPending;
    logic [TAG_BITS-1:0]   r_reqTag;
    logic [INDEX_BITS-1:0] r_reqIndex;
    logic [LINES-1:0]      r_valid;
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [31:0]           r_data [LINES*LINE_WORDS];

    state_t                w_nextState;
    logic [CNT_BITS-1:0]   w_nextCnt;
    logic                  w_nextFlushPending;
    logic [TAG_BITS-1:0]   w_nextReqTag;
    logic [INDEX_BITS-1:0] w_nextReqIndex;
    logic                  w_clearValid;
    logic                  w_setValid;
    logic                  w_fillWord;
    logic                  w_memRead;
    logic [31:0]           w_memAddress;

    logic [TAG_BITS-1:0]   w_tag;
    logic [INDEX_BITS-1:0] w_index;
    logic [WORD_BITS-1:0]  w_word;
    logic [1:0]            w_unusedAddrBits;
    logic                  w_hit;
    logic                  w_beatOk;
    logic                  w_beatFault;
    logic                  w_lastBeat;

    assign w_tag            = instr_address_in[31 -: TAG_BITS];
    assign w_index          = instr_address_in[OFFSET_BITS +: INDEX_BITS];
    assign w_word           = instr_address_in[2 +: WORD_BITS];
    assign w_unusedAddrBits = instr_address_in[1:0];
    assign w_hit       = (r_state == S_IDLE) && instr_read_in && r_valid[w_index]
                         && (r_tag[w_index] == w_tag);
    assign w_beatOk    = mem.mem_ready_in && !mem.mem_fault_in;
    assign w_beatFault = mem.mem_ready_in && mem.mem_fault_in;
    assign w_lastBeat  = (r_cnt[WORD_BITS-1:0] == WORD_BITS'(LINE_WORDS - 1));

    assign mem.mem_read_out    = w_memRead;
    assign mem.mem_address_out = w_memAddress;

    always_comb begin
        w_nextState          = r_state;
        w_nextCnt            = r_cnt;
        w_nextFlushPending   = r_flushPending;
        w_nextReqTag         = r_reqTag;
        w_nextReqIndex       = r_reqIndex;
        w_clearValid         = 1'b0;
        w_setValid           = 1'b0;
        w_fillWord           = 1'b0;
        w_memRead            = 1'b0;
        w_memAddress         = 32'h0;
        instr_read_value_out = NOP;
        instr_fault_out      = 1'b0;
        instr_stall_out      = 1'b0;

        case (r_state)
            S_INVAL: begin
                instr_stall_out = 1'b1;
                w_clearValid    = 1'b1;
                if (flush_in) begin
                    w_nextCnt = '0;
                end else if (r_cnt == CNT_BITS'(LINES - 1)) begin
                    w_nextCnt   = '0;
                    w_nextState = S_IDLE;
                end else begin
                    w_nextCnt = r_cnt + CNT_BITS'(1);
                end
            end
            S_IDLE: begin
                if (w_hit) begin
                    instr_read_value_out = r_data[{w_index, w_word}];
                end else if (instr_read_in) begin
                    instr_stall_out = 1'b1;
                end
                if (flush_in) begin
                    w_nextState = S_INVAL;
                    w_nextCnt   = '0;
                end else if (instr_read_in && !w_hit) begin
                    w_nextState    = S_REFILL;
                    w_nextCnt      = '0;
                    w_nextReqTag   = w_tag;
                    w_nextReqIndex = w_index;
                end
            end
            S_REFILL: begin
                instr_stall_out = 1'b1;
                w_memRead       = 1'b1;
                w_memAddress    = {r_reqTag, r_reqIndex, r_cnt[WORD_BITS-1:0], 2'b00};
                if (flush_in) begin
                    w_nextFlushPending = 1'b1;
                end
                if (w_beatFault) begin
                    w_nextState = S_FAULT;
                    w_nextCnt   = '0;
                end else if (w_beatOk) begin
                    w_fillWord = 1'b1;
                    if (w_lastBeat) begin
                        w_nextCnt = '0;
                        // A flush seen at any point of the refill leaves the line invalid.
                        if (r_flushPending || flush_in) begin
                            w_nextState        = S_INVAL;
                            w_nextFlushPending = 1'b0;
                        end else begin
                            w_setValid  = 1'b1;
                            w_nextState = S_IDLE;
                        end
                    end else begin
                        w_nextCnt = r_cnt + CNT_BITS'(1);
                    end
                end
            end
            S_FAULT: begin
                instr_fault_out = 1'b1;
                if (r_flushPending || flush_in) begin
                    w_nextState        = S_INVAL;
                    w_nextCnt          = '0;
                    w_nextFlushPending = 1'b0;
                end else begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_INVAL;
                w_nextCnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= S_INVAL;
            r_cnt          <= '0;
            r_flushPending <= 1'b0;
        end else begin
            r_state        <= w_nextState;
            r_cnt          <= w_nextCnt;
            r_flushPending <= w_nextFlushPending;
        end
        r_reqTag   <= w_nextReqTag;
        r_reqIndex <= w_nextReqIndex;
    end

    // Storage arrays carry no reset; the INVAL sweep is what makes the cache empty.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (w_clearValid) begin
                r_valid[r_cnt[INDEX_BITS-1:0]] <= 1'b0;
            end
            if (w_setValid) begin
                r_valid[r_reqIndex] <= 1'b1;
                r_tag[r_reqIndex]   <= r_reqTag;
            end
            if (w_fillWord) begin
                r_data[{r_reqIndex, r_cnt[WORD_BITS-1:0]}] <= mem.mem_read_value_in;
            end
        end
    end

`ifdef RV32_ICACHE_STATS_EN
    logic [31:0] r_hitCount;
    logic [31:0] r_missCount;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hitCount  <= 32'h0;
            r_missCount <= 32'h0;
        end else begin
            if (w_hit) begin
                r_hitCount <= r_hitCount + 32'h1;
            end
            if ((r_state == S_IDLE) && (w_nextState == S_REFILL)) begin
                r_missCount <= r_missCount + 32'h1;
            end
        end
    end

    assign hit_count_out  = r_hitCount;
    assign miss_count_out = r_missCount;
`endif
endmodule

// File: tb/tb_rv32_icache.sv
// Self-checking bench for rv32_icache: reset sweep, hits/misses, eviction, faults, flushes, reset mid-refill.
// Honours RV32_ICACHE_STATS_EN when the design is built with it.
module tb_rv32_icache;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_read_in;
    logic [31:0] instr_address_in;
    logic [31:0] instr_read_value_out;
    logic        instr_fault_out;
    logic        instr_stall_out;
    logic        flush_in;
`ifdef RV32_ICACHE_STATS_EN
    logic [31:0] hit_count_out;
    logic [31:0] miss_count_out;
`endif

    int errors = 0;
    int checks = 0;
    int expHits = 0;
    int expMisses = 0;

    rv32_icache_if memBus ();

    rv32_icache dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .instr_read_in        (instr_read_in),
        .instr_address_in     (instr_address_in),
        .instr_read_value_out (instr_read_value_out),
        .instr_fault_out      (instr_fault_out),
        .instr_stall_out      (instr_stall_out),
        .flush_in             (flush_in),
        .mem                  (memBus)
`ifdef RV32_ICACHE_STATS_EN
        ,
        .hit_count_out        (hit_count_out),
        .miss_count_out       (miss_count_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        read;
        logic [31:0] addr;
        logic        expStall;
        logic [31:0] expValue;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return ~a ^ 32'hC0DE_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic read, input logic [31:0] addr, input logic flush);
        instr_read_in    = read;
        instr_address_in = addr;
        flush_in         = flush;
    endtask

    task automatic checkStats(input string name);
`ifdef RV32_ICACHE_STATS_EN
        checkOutput({name, "_hits"}, hit_count_out, 32'(expHits));
        checkOutput({name, "_misses"}, miss_count_out, 32'(expMisses));
`else
        $display("[TB] %s: statistics not built", name);
`endif
    endtask

    // Entered right after a negedge; leaves one cycle later at the next negedge.
    task automatic startMiss(input logic [31:0] addr);
        applyStimulus(1'b1, addr, 1'b0);
        #1;
        checkOutput($sformatf("miss_stall_%h", addr), 32'(instr_stall_out), 32'd1);
        checkOutput($sformatf("miss_value_%h", addr), instr_read_value_out, NOP);
        checkOutput($sformatf("miss_fault_%h", addr), 32'(instr_fault_out), 32'd0);
        checkOutput($sformatf("miss_memrd_%h", addr), 32'(memBus.mem_read_out), 32'd0);
        expMisses++;
        @(negedge clk);
    endtask

    task automatic checkHitAfter(input logic [31:0] addr);
        applyStimulus(1'b1, addr, 1'b0);
        #1;
        checkOutput($sformatf("hit_stall_%h", addr), 32'(instr_stall_out), 32'd0);
        checkOutput($sformatf("hit_value_%h", addr), instr_read_value_out, memWord({addr[31:2], 2'b00}));
        expHits++;
        @(negedge clk);
    endtask

    // Serves refill beats from the bench memory; a beat index of -1 disables that feature.
    task automatic doRefill(input logic [31:0] base, input int faultBeat, input int flushBeat,
                            input int waitBeat, input int stopBeat);
        for (int b = 0; b < 4 && b < stopBeat; b++) begin
            logic [31:0] a;
            a = base + 32'(b * 4);
            #1;
            checkOutput($sformatf("memrd_%h_b%0d", base, b), 32'(memBus.mem_read_out), 32'd1);
            checkOutput($sformatf("memaddr_%h_b%0d", base, b), memBus.mem_address_out, a);
            checkOutput($sformatf("rstall_%h_b%0d", base, b), 32'(instr_stall_out), 32'd1);
            if (b == waitBeat) begin
                @(negedge clk);
                #1;
                checkOutput($sformatf("hold_memrd_%h_b%0d", base, b), 32'(memBus.mem_read_out), 32'd1);
                checkOutput($sformatf("hold_memaddr_%h_b%0d", base, b), memBus.mem_address_out, a);
            end
            memBus.mem_ready_in      = 1'b1;
            memBus.mem_read_value_in = memWord(a);
            memBus.mem_fault_in      = (b == faultBeat);
            flush_in                 = (b == flushBeat);
            @(negedge clk);
            memBus.mem_ready_in      = 1'b0;
            memBus.mem_read_value_in = 32'h0;
            memBus.mem_fault_in      = 1'b0;
            flush_in                 = 1'b0;
            if (b == faultBeat) begin
                return;
            end
        end
    endtask

    task automatic countSweep(input string name);
        int  n;
        bit  done;
        bit  memReadSeen;
        n = 0;
        done = 1'b0;
        memReadSeen = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 300 && !done; i++) begin
            #1;
            if (instr_stall_out) begin
                n++;
                if (memBus.mem_read_out) begin
                    memReadSeen = 1'b1;
                end
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        checkOutput({name, "_cycles"}, 32'(n), 32'd64);
        checkOutput({name, "_memrd"}, 32'(memReadSeen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_n                  = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        memBus.mem_ready_in      = 1'b0;
        memBus.mem_read_value_in = 32'h0;
        memBus.mem_fault_in      = 1'b0;

        // Reset state and the post-reset invalidate sweep.
        @(negedge clk);
        #1;
        checkOutput("rst_stall", 32'(instr_stall_out), 32'd1);
        checkOutput("rst_memrd", 32'(memBus.mem_read_out), 32'd0);
        checkOutput("rst_memaddr", memBus.mem_address_out, 32'h0);
        checkOutput("rst_value", instr_read_value_out, NOP);
        checkOutput("rst_fault", 32'(instr_fault_out), 32'd0);
        checkStats("rst");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        countSweep("reset_sweep");
        #1;
        checkOutput("idle_noread_value", instr_read_value_out, NOP);
        checkOutput("idle_noread_memrd", 32'(memBus.mem_read_out), 32'd0);
        @(negedge clk);

        // Cold miss, with one wait state on beat 1, then table-driven hits in the line.
        startMiss(32'h100);
        doRefill(32'h100, -1, -1, 1, 4);
        checkHitAfter(32'h100);
        vecs[0] = '{1'b1, 32'h10C, 1'b0, memWord(32'h10C)};
        vecs[1] = '{1'b1, 32'h104, 1'b0, memWord(32'h104)};
        vecs[2] = '{1'b0, 32'h100, 1'b0, NOP};
        vecs[3] = '{1'b1, 32'h108, 1'b0, memWord(32'h108)};
        vecs[4] = '{1'b1, 32'h102, 1'b0, memWord(32'h100)};
        vecs[5] = '{1'b1, 32'h10F, 1'b0, memWord(32'h10C)};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].read, vecs[i].addr, 1'b0);
            #1;
            checkOutput($sformatf("vec%0d_stall", i), 32'(instr_stall_out), 32'(vecs[i].expStall));
            checkOutput($sformatf("vec%0d_value", i), instr_read_value_out, vecs[i].expValue);
            checkOutput($sformatf("vec%0d_memrd", i), 32'(memBus.mem_read_out), 32'd0);
            if (vecs[i].read) begin
                expHits++;
            end
            @(negedge clk);
        end

        // Conflict eviction at index 0x10.
        startMiss(32'h500);
        doRefill(32'h500, -1, -1, -1, 4);
        checkHitAfter(32'h500);
        startMiss(32'h100);
        doRefill(32'h100, -1, -1, -1, 4);
        checkHitAfter(32'h100);
        applyStimulus(1'b0, 32'h0, 1'b0);
        #1;
        checkStats("after_evict");
        @(negedge clk);

        // Bus fault on beat 2: one fault cycle, line stays invalid.
        startMiss(32'h200);
        doRefill(32'h200, 2, -1, -1, 4);
        #1;
        checkOutput("fault_flag", 32'(instr_fault_out), 32'd1);
        checkOutput("fault_stall", 32'(instr_stall_out), 32'd0);
        checkOutput("fault_value", instr_read_value_out, NOP);
        checkOutput("fault_memrd", 32'(memBus.mem_read_out), 32'd0);
        @(negedge clk);
        startMiss(32'h200);
        doRefill(32'h200, -1, -1, -1, 4);
        checkHitAfter(32'h200);

        // Flush on beat 1: refill completes, then a full sweep, and the line is not kept.
        startMiss(32'h300);
        doRefill(32'h300, -1, 1, -1, 4);
        countSweep("refill_flush_sweep");
        startMiss(32'h300);
        doRefill(32'h300, -1, -1, -1, 4);
        checkHitAfter(32'h300);
        applyStimulus(1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("idle_flush_stall", 32'(instr_stall_out), 32'd0);
        @(negedge clk);
        countSweep("idle_flush_sweep");
        startMiss(32'h100);
        doRefill(32'h100, -1, -1, -1, 4);
        checkHitAfter(32'h100);

        // Reset while beat 2 waits for ready.
        startMiss(32'h400);
        doRefill(32'h400, -1, -1, -1, 2);
        #1;
        checkOutput("prereset_memaddr", memBus.mem_address_out, 32'h408);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("midreset_memrd", 32'(memBus.mem_read_out), 32'd0);
        checkOutput("midreset_stall", 32'(instr_stall_out), 32'd1);
        checkOutput("midreset_memaddr", memBus.mem_address_out, 32'h0);
        checkOutput("midreset_value", instr_read_value_out, NOP);
        checkOutput("midreset_fault", 32'(instr_fault_out), 32'd0);
        expHits = 0;
        expMisses = 0;
        checkStats("midreset");
        reset_n = 1'b1;
        countSweep("midreset_sweep");
        startMiss(32'h100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
